// File: rtl/peripheral_bcd2bin.sv
// peripheral_bcd2bin: j1-bus peripheral that converts a 5-digit packed-BCD value to a
// 17-bit binary result using an iterative reverse double-dabble engine.
module peripheral_bcd2bin #(
    parameter int DECIMAL_DIGITS = 5,
    parameter int BIN_WIDTH      = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out
);
    localparam int BCD_WIDTH  = 4 * DECIMAL_DIGITS;
    localparam int WORK_WIDTH = BCD_WIDTH + BIN_WIDTH;
    localparam int CNT_WIDTH  = $clog2(BIN_WIDTH);
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(BIN_WIDTH - 1);

    localparam logic [4:0] ADDR_BCD_LO = 5'h04;
    localparam logic [4:0] ADDR_BCD_HI = 5'h08;
    localparam logic [4:0] ADDR_START  = 5'h0C;
    localparam logic [4:0] ADDR_RESULT = 5'h10;
    localparam logic [4:0] ADDR_STATUS = 5'h14;

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT} state_t;

    state_t                 state;
    logic [15:0]            bcd_lo;
    logic [3:0]             bcd_hi;
    logic [BCD_WIDTH-1:0]   bcd;
    logic [BIN_WIDTH-1:0]   result;
    logic                   done;
    logic                   err;
    logic                   busy;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [WORK_WIDTH-1:0]  work;
    logic [WORK_WIDTH-1:0]  shifted;
    logic [WORK_WIDTH-1:0]  adjusted;
    logic                   digit_err;
    logic                   wr_en;
    logic                   start_req;

    assign bcd       = {bcd_hi, bcd_lo};
    assign wr_en     = cs && wr && !busy;
    assign start_req = wr_en && (addr == ADDR_START) && d_in[0];

    // One reverse double-dabble step: shift right, then pull every BCD digit >= 8 back by 3.
    always_comb begin
        shifted  = work >> 1;
        adjusted = shifted;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (shifted[BIN_WIDTH + 4*i +: 4] >= 4'd8)
                adjusted[BIN_WIDTH + 4*i +: 4] = shifted[BIN_WIDTH + 4*i +: 4] - 4'd3;
        end
    end

    always_comb begin
        digit_err = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9)
                digit_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bcd_lo <= '0;
            bcd_hi <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            work   <= '0;
        end else begin
            if (wr_en && addr == ADDR_BCD_LO)
                bcd_lo <= d_in;
            if (wr_en && addr == ADDR_BCD_HI)
                bcd_hi <= d_in[3:0];

            case (state)
                IDLE: begin
                    if (start_req) begin
                        state <= CHECK;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                CHECK: begin
                    if (digit_err) begin
                        err    <= 1'b1;
                        done   <= 1'b1;
                        result <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        work  <= {bcd, {BIN_WIDTH{1'b0}}};
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= adjusted;
                    cnt  <= cnt + 1'b1;
                    // Low bits are untouched by the digit adjust, so the raw shift is the answer.
                    if (cnt == LAST_ITER) begin
                        result <= shifted[BIN_WIDTH-1:0];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (cs && rd) begin
            case (addr)
                ADDR_BCD_LO: d_out <= {16'b0, bcd_lo};
                ADDR_BCD_HI: d_out <= {28'b0, bcd_hi};
                ADDR_RESULT: d_out <= {{(32-BIN_WIDTH){1'b0}}, result};
                ADDR_STATUS: d_out <= {29'b0, err, busy, done};
                default:     d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bcd2bin.sv
// tb_peripheral_bcd2bin: table-driven bench for the BCD-to-binary peripheral, plus directed
// sequences for error, busy-lockout, reset-abort and read-path corner cases.
module tb_peripheral_bcd2bin;
    localparam logic [4:0] A_LO     = 5'h04;
    localparam logic [4:0] A_HI     = 5'h08;
    localparam logic [4:0] A_START  = 5'h0C;
    localparam logic [4:0] A_RESULT = 5'h10;
    localparam logic [4:0] A_STATUS = 5'h14;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    typedef struct {
        logic [15:0] lo;
        logic [3:0]  hi;
        logic [16:0] expected;
    } vec_t;

    vec_t vecs[7];

    peripheral_bcd2bin dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [15:0] data);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = data;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] data);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0; rd = 1'b0; addr = '0;
        data = d_out;
    endtask

    // Polls STATUS; returns the edge on which the first done=1 read was sampled (-1 on timeout).
    task automatic poll_done(output int done_edge, output logic [31:0] status);
        done_edge = -1;
        status    = '0;
        for (int k = 0; k < 40; k++) begin
            bus_read(A_STATUS, status);
            if (status[0]) begin
                done_edge = edge_no;
                break;
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] lo, input logic [3:0] hi, output int start_edge);
        bus_write(A_LO, lo);
        bus_write(A_HI, {12'h000, hi});
        bus_write(A_START, 16'h0001);
        start_edge = edge_no;
    endtask

    initial begin
        logic [31:0] rdata;
        logic [31:0] status;
        int          start_edge;
        int          done_edge;

        vecs[0] = '{lo: 16'h2345, hi: 4'h1, expected: 17'h03039};
        vecs[1] = '{lo: 16'h9999, hi: 4'h9, expected: 17'h1869F};
        vecs[2] = '{lo: 16'h0000, hi: 4'h0, expected: 17'h00000};
        vecs[3] = '{lo: 16'h0001, hi: 4'h0, expected: 17'h00001};
        vecs[4] = '{lo: 16'h0000, hi: 4'h1, expected: 17'h02710};
        vecs[5] = '{lo: 16'h0505, hi: 4'h5, expected: 17'h0C549};
        vecs[6] = '{lo: 16'h8888, hi: 4'h8, expected: 17'h15B38};

        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;
        checkOutput("reset d_out", d_out, 32'h0);
        bus_read(A_STATUS, rdata);
        checkOutput("reset status", rdata, 32'h0);
        bus_read(A_RESULT, rdata);
        checkOutput("reset result", rdata, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].lo, vecs[i].hi, start_edge);
            poll_done(done_edge, status);
            checkOutput($sformatf("vec%0d latency", i), 32'(done_edge - start_edge), 32'd19);
            checkOutput($sformatf("vec%0d status", i), status, 32'h1);
            bus_read(A_RESULT, rdata);
            checkOutput($sformatf("vec%0d result", i), rdata, {15'b0, vecs[i].expected});
        end

        // Invalid low digit, then recovery with a valid operand.
        applyStimulus(16'h12A4, 4'h0, start_edge);
        poll_done(done_edge, status);
        checkOutput("err latency", 32'(done_edge - start_edge), 32'd2);
        checkOutput("err status", status, 32'h5);
        bus_read(A_RESULT, rdata);
        checkOutput("err result", rdata, 32'h0);
        applyStimulus(16'h0001, 4'h0, start_edge);
        bus_read(A_STATUS, rdata);
        checkOutput("recover busy", rdata, 32'h2);
        poll_done(done_edge, status);
        checkOutput("recover latency", 32'(done_edge - start_edge), 32'd19);
        checkOutput("recover status", status, 32'h1);
        bus_read(A_RESULT, rdata);
        checkOutput("recover result", rdata, 32'h1);

        // Invalid high digit.
        applyStimulus(16'h0000, 4'hA, start_edge);
        poll_done(done_edge, status);
        checkOutput("hi err status", status, 32'h5);

        // Writes and START while busy must be ignored.
        applyStimulus(16'h0042, 4'h0, start_edge);
        for (int k = 0; k < 4; k++) idle_cycle();
        bus_write(A_LO, 16'h9999);
        bus_write(A_START, 16'h0001);
        poll_done(done_edge, status);
        checkOutput("busy latency", 32'(done_edge - start_edge), 32'd19);
        bus_read(A_RESULT, rdata);
        checkOutput("busy result", rdata, 32'd42);
        bus_read(A_LO, rdata);
        checkOutput("busy lo kept", rdata, 32'h0042);

        // Reset in the middle of a conversion.
        applyStimulus(16'h2345, 4'h1, start_edge);
        while (edge_no < start_edge + 9) idle_cycle();
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        checkOutput("abort d_out", d_out, 32'h0);
        bus_read(A_STATUS, rdata);
        checkOutput("abort status", rdata, 32'h0);
        bus_read(A_RESULT, rdata);
        checkOutput("abort result", rdata, 32'h0);
        bus_read(A_LO, rdata);
        checkOutput("abort lo", rdata, 32'h0);
        bus_read(A_HI, rdata);
        checkOutput("abort hi", rdata, 32'h0);
        bus_write(A_START, 16'h0001);
        start_edge = edge_no;
        poll_done(done_edge, status);
        checkOutput("zero latency", 32'(done_edge - start_edge), 32'd19);
        bus_read(A_RESULT, rdata);
        checkOutput("zero result", rdata, 32'h0);

        // START with d_in[0]=0 does nothing.
        bus_write(A_START, 16'h0002);
        bus_read(A_STATUS, rdata);
        checkOutput("nostart status", rdata, 32'h1);

        // Read path corners.
        bus_write(A_HI, 16'hFFF7);
        bus_read(A_HI, rdata);
        checkOutput("hi readback", rdata, 32'h7);
        cs = 1'b0; rd = 1'b1; addr = A_STATUS;
        idle_cycle();
        rd = 1'b0; addr = '0;
        checkOutput("no cs hold", d_out, 32'h7);
        bus_read(5'h18, rdata);
        checkOutput("unmapped read", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/peripheral_bcd2bin.md
# peripheral_bcd2bin

Memory-mapped bus peripheral that converts a 5-digit packed-BCD value into a 17-bit unsigned binary result. It uses an iterative reverse double-dabble engine: shift right, then subtract 3 from every BCD digit ≥ 8. It sits on the same j1 I/O bus as the other peripherals and is the inverse companion of the binary-to-BCD peripheral. Firmware uses it to turn decimal keypad or display entries back into binary.

## Interface
- DECIMAL_DIGITS, 5, number of BCD input digits; fixed at 5 in this revision.
- BIN_WIDTH, 17, binary result width; ceil(log2(10^5)) = 17.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- d_in  in  16  bus write data.
- cs  in  1  peripheral chip select.
- addr  in  5  register address.
- rd  in  1  read strobe; valid only with cs.
- wr  in  1  write strobe; valid only with cs.
- d_out  out  32  registered read data.

## Operation
- Address map. Any address not listed: writes are ignored and reads return 0.
  - 0x04 BCD_LO: R/W; digits 3..0 = d_in[15:0].
  - 0x08 BCD_HI: R/W; digit 4 = d_in[3:0]; reads back {28'b0, digit4}.
  - 0x0C START: write-only. A write with d_in[0]=1 starts a conversion. A write with d_in[0]=0 has no effect.
  - 0x10 RESULT: read-only; returns {15'b0, result[16:0]}.
  - 0x14 STATUS: read-only; returns {29'b0, err, busy, done}.
- Writes to BCD_LO, BCD_HI and START are ignored while busy=1.
- A START accepted while busy=1 is dropped.
- FSM states:
  - IDLE: busy=0. On an accepted START: go to CHECK; set busy=1; clear done and err.
  - CHECK:
    - If any digit > 9: set err=1, done=1, result=0, busy=0; go to IDLE.
    - Otherwise: load work = {bcd[19:0], 17'b0}; set cnt=0; go to SHIFT.
  - SHIFT: one iteration per cycle.
    - Shift work right by 1.
    - In the shifted value, subtract 3 from each 4-bit BCD digit that is ≥ 8.
    - Increment cnt.
    - On the 17th iteration (cnt=16): result = work[16:0] after the shift; set done=1, busy=0; go to IDLE.
- done and err are sticky until the next accepted START or reset.
- result holds its value until the next conversion completes or errors.
- Reading does not clear any flag.
- The read mux updates d_out only on cs&&rd and holds d_out otherwise.
- Reset values: d_out=0, BCD regs=0, result=0, done=0, err=0, busy=0, state=IDLE, cnt=0.
- Reset during CHECK or SHIFT aborts the conversion. Every register returns to its reset value on that edge, and no done flag is produced.

## Timing
- Edge 0: START write is sampled; busy=1 from this edge.
- Edge 1: CHECK.
- Edges 2..18: 17 SHIFT iterations.
- Edge 18: result valid, done=1, busy=0.
- Conversion latency is 18 cycles from the START edge to done, and is constant for all valid inputs.
- Error path: err=1 and done=1 at edge 1, i.e. 1 cycle latency.
- Back-to-back operation: a new START may be accepted on the edge immediately after done rises.
- Read latency: d_out reflects a register 1 cycle after the edge on which cs&&rd is sampled. The read sees state as of that sampling edge.
  - A STATUS read sampled at edge 18 returns the pre-update state (busy=1).
  - A STATUS read sampled at edge 19 returns done=1.

## Test plan
- Write BCD_LO=0x2345, BCD_HI=0x1, then START. Poll STATUS until done. Required: RESULT=0x03039 (12345), err=0, exactly 18 cycles after the START edge.
- BCD 99999 (LO=0x9999, HI=0x9) → RESULT=0x1869F. BCD 00000 → RESULT=0. BCD 00001 → RESULT=1. BCD 10000 → RESULT=0x2710.
- Invalid digit: LO=0x12A4, HI=0x0, then START. Required: err=1 and done=1 one cycle later; RESULT=0.
  - Then write a valid value and START: err and done clear, and the conversion completes normally.
- START at edge 0 with LO=0x0042; at edge 5 write LO=0x9999 and issue START again. Required: both writes ignored, final RESULT=42, and exactly one done rise at edge 18.
- Assert reset at edge 10 of a conversion. Required next cycle: STATUS=0, RESULT=0, d_out=0, BCD regs=0.
  - A subsequent START with no operand writes converts 0 → 0.
- Reads at unmapped address 0x18 and a read with cs=0: d_out=0, or d_out unchanged respectively. A read of BCD_HI returns only the low 4 bits written.
